// File: rtl/wbc_vic_if.sv
// Bus bundle between the vectored interrupt controller, its devices and the CPU.
// The slave modport is the controller's view; the master modport drives it.
interface wbc_vic_if #(
  parameter int N = 4
);
  logic [N-1:0]    irq;
  logic [N-1:0]    mask;
  logic [16*N-1:0] dev_vec;
  logic [N-1:0]    dev_ack;
  logic            virq;
  logic            istb;
  logic [15:0]     ivec;
  logic            iack;

  modport slave (
    input  irq, mask, dev_vec, istb,
    output dev_ack, virq, ivec, iack
  );

  modport master (
    output irq, mask, dev_vec, istb,
    input  dev_ack, virq, ivec, iack
  );
endinterface

// File: rtl/wbc_vic.sv
// Fixed-priority vectored interrupt controller: arbitrates device requests,
// serves the winner's vector on the CPU strobe and acknowledges the device.
module wbc_vic #(
  parameter int          N        = 4,
  parameter logic [15:0] SPUR_VEC = 16'o000000
) (
  input logic       clk_p,
  input logic       rst_n,
  wbc_vic_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ACK, GAP} state_e;

  state_e          state_q, state_d;
  logic            virq_q, virq_d;
  logic            iack_q, iack_d;
  logic [15:0]     ivec_q, ivec_d;
  logic [N-1:0]    devAck_q, devAck_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            spur_q, spur_d;

  logic [N-1:0]    elig;
  logic [IW-1:0]   win;
  logic [15:0]     winVec;

  always_comb begin
    elig   = bus.irq & ~bus.mask;
    win    = '0;
    winVec = '0;
    // Scan downward so the lowest set index overwrites last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win    = IW'(i);
        winVec = bus.dev_vec[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    virq_d   = virq_q;
    iack_d   = iack_q;
    ivec_d   = ivec_q;
    devAck_d = '0;
    idx_d    = idx_q;
    spur_d   = spur_q;
    unique case (state_q)
      IDLE: begin
        virq_d = |elig;
        iack_d = 1'b0;
        if (bus.istb) begin
          virq_d  = 1'b0;
          state_d = ACK;
          // A strobe without a live request still completes, with no device ack.
          if (virq_q && (|elig)) begin
            idx_d  = win;
            ivec_d = winVec;
            spur_d = 1'b0;
          end else begin
            ivec_d = SPUR_VEC;
            spur_d = 1'b1;
          end
        end
      end
      ACK: begin
        virq_d = 1'b0;
        if (bus.istb) begin
          iack_d = 1'b1;
        end else begin
          iack_d  = 1'b0;
          ivec_d  = '0;
          state_d = GAP;
          for (int i = 0; i < N; i++) begin
            devAck_d[i] = !spur_q && (idx_q == IW'(i));
          end
        end
      end
      GAP: begin
        virq_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      virq_q   <= 1'b0;
      iack_q   <= 1'b0;
      ivec_q   <= '0;
      devAck_q <= '0;
      idx_q    <= '0;
      spur_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      virq_q   <= virq_d;
      iack_q   <= iack_d;
      ivec_q   <= ivec_d;
      devAck_q <= devAck_d;
      idx_q    <= idx_d;
      spur_q   <= spur_d;
    end
  end

  assign bus.virq    = virq_q;
  assign bus.iack    = iack_q;
  assign bus.ivec    = ivec_q;
  assign bus.dev_ack = devAck_q;
endmodule
